// File: rtl/add_sub_sched_pkg.sv
// Shared types for the round-robin add/sub scheduler.
// Optional signed-overflow output: ADD_SUB_SCHED_OVF_EN.
package add_sub_sched_pkg;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/add_sub_sched_if.sv
// Request/response bundle between the issue logic and the scheduler.
// rsp_ovf exists only when ADD_SUB_SCHED_OVF_EN is defined.
interface add_sub_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_a;
  logic [NUM_REQ*32-1:0] req_b;
  logic [NUM_REQ-1:0]    req_sub;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_sum;
  logic                  rsp_cout;
`ifdef ADD_SUB_SCHED_OVF_EN
  logic                  rsp_ovf;
`endif

  modport master (
    output req_valid, req_a, req_b, req_sub, rsp_ready,
`ifdef ADD_SUB_SCHED_OVF_EN
    input  rsp_ovf,
`endif
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
  );

  modport slave (
    input  req_valid, req_a, req_b, req_sub, rsp_ready,
`ifdef ADD_SUB_SCHED_OVF_EN
    output rsp_ovf,
`endif
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
  );
endinterface

// File: rtl/add_sub_rr_scheduler_adder.sv
// 32-bit Kogge-Stone adder-subtractor; s=1 computes a-b.
module add_sub_adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        s,
  output logic        cout,
  output logic [31:0] sum
);

  logic [31:0] be;
  logic [31:0] g [6];
  logic [31:0] p [6];
  logic [32:0] c;

  assign be = b ^ {32{s}};

  always_comb begin
    g[0] = a & be;
    p[0] = a ^ be;
    for (int l = 0; l < 5; l++) begin
      for (int i = 0; i < 32; i++) begin
        if (i >= (1 << l)) begin
          g[l+1][i] = g[l][i] | (p[l][i] & g[l][i-(1<<l)]);
          p[l+1][i] = p[l][i] & p[l][i-(1<<l)];
        end else begin
          g[l+1][i] = g[l][i];
          p[l+1][i] = p[l][i];
        end
      end
    end
    // fold the carry-in (the subtract one) into every prefix
    c[0] = s;
    for (int i = 0; i < 32; i++)
      c[i+1] = g[5][i] | (p[5][i] & s);
  end

  assign sum  = p[0] ^ c[31:0];
  assign cout = c[32];

endmodule

// File: rtl/add_sub_rr_scheduler_rr_arbiter.sv
// Round-robin arbiter: first active request at or after ptr.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx
);

  always_comb begin
    int  k;
    logic found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    k     = 0;
    for (int o = 0; o < NUM_REQ; o++) begin
      k = (int'(ptr) + o) % NUM_REQ;
      if (en && !found && req[k]) begin
        gnt[k] = 1'b1;
        idx    = ID_W'(k);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/add_sub_rr_scheduler.sv
// Shares one add/sub unit among NUM_REQ requesters, round-robin.
// Define ADD_SUB_SCHED_OVF_EN to add the rsp_ovf output.
module add_sub_rr_scheduler
  import add_sub_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input logic          clk,
  input logic          rst_n,
  add_sub_sched_if.slave bus
);

  slot_e             state_q, state_d;
  logic [ID_W-1:0]   ptr_q;
  logic [ID_W-1:0]   id_q;
  logic [31:0]       sum_q;
  logic              cout_q;
  logic              slot_free;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]   gidx;
  logic              any_gnt;
  logic [31:0]       op_a, op_b;
  logic              op_s;
  logic [31:0]       add_sum;
  logic              add_cout;

  assign slot_free = (state_q == SLOT_EMPTY) | bus.rsp_ready;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req (bus.req_valid),
    .en  (slot_free & rst_n),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (gidx)
  );

  assign any_gnt       = |gnt;
  assign bus.req_ready = gnt;

  assign op_a = bus.req_a[32*int'(gidx) +: 32];
  assign op_b = bus.req_b[32*int'(gidx) +: 32];
  assign op_s = bus.req_sub[gidx];

  add_sub_adder u_add (
    .a    (op_a),
    .b    (op_b),
    .s    (op_s),
    .cout (add_cout),
    .sum  (add_sum)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SLOT_EMPTY: if (any_gnt) state_d = SLOT_FULL;
      SLOT_FULL:
        if (bus.rsp_ready && !any_gnt)
          state_d = SLOT_EMPTY;
      default: state_d = SLOT_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= SLOT_EMPTY;
      ptr_q   <= '0;
      id_q    <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (any_gnt) begin
        id_q   <= gidx;
        sum_q  <= add_sum;
        cout_q <= add_cout;
        ptr_q  <= (int'(gidx) == NUM_REQ-1) ? '0 : gidx + 1'b1;
      end
    end
  end

  assign bus.rsp_valid = (state_q == SLOT_FULL);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_sum   = sum_q;
  assign bus.rsp_cout  = cout_q;

`ifdef ADD_SUB_SCHED_OVF_EN
  logic ovf_q;
  logic ovf_d;
  logic beff31;

  assign beff31 = op_b[31] ^ op_s;
  assign ovf_d  = (op_a[31] == beff31) & (add_sum[31] != op_a[31]);

  always_ff @(posedge clk) begin
    if (!rst_n)       ovf_q <= 1'b0;
    else if (any_gnt) ovf_q <= ovf_d;
  end

  assign bus.rsp_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_add_sub_rr_scheduler.sv
// Directed bench for add_sub_rr_scheduler (NUM_REQ=4).
// Checks rsp_ovf too when ADD_SUB_SCHED_OVF_EN is defined.
module tb_add_sub_rr_scheduler;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  add_sub_sched_if #(.NUM_REQ(N), .ID_W(2)) bus ();

  add_sub_rr_scheduler #(.NUM_REQ(N), .ID_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] a,
                        input logic [31:0] b, input logic s);
    bus.req_a[32*i +: 32] = a;
    bus.req_b[32*i +: 32] = b;
    bus.req_sub[i]        = s;
  endtask

  initial begin
    vecs[0] = '{0, 32'h5,        32'h3,        1'b0, 32'h8,        1'b0, 1'b0};
    vecs[1] = '{2, 32'h3,        32'h5,        1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[2] = '{2, 32'hFFFFFFFF, 32'h1,        1'b0, 32'h0,        1'b1, 1'b0};
    vecs[3] = '{1, 32'h10,       32'h10,       1'b1, 32'h0,        1'b1, 1'b0};
    vecs[4] = '{3, 32'h80000000, 32'h80000000, 1'b0, 32'h0,        1'b1, 1'b1};
    vecs[5] = '{0, 32'h7FFFFFFF, 32'h1,        1'b0, 32'h80000000, 1'b0, 1'b1};
    vecs[6] = '{1, 32'h80000000, 32'h1,        1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
    vecs[7] = '{3, 32'h12345678, 32'h0,        1'b0, 32'h12345678, 1'b0, 1'b0};

    rst_n         = 1'b0;
    bus.req_valid = '1;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) set_op(i, 32'(i*16), 32'h1, 1'b0);

    // reset held two cycles with every requester asking
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_ready", 32'(bus.req_ready), 32'h0);
      chk("rst_valid", 32'(bus.rsp_valid), 32'h0);
    end
    chk("rst_sum", bus.rsp_sum, 32'h0);
    chk("rst_id", 32'(bus.rsp_id), 32'h0);

    // fairness: grants 0,1,2,3,0,1 back to back
    rst_n = 1'b1;
    #1;
    for (int g = 0; g < 6; g++) begin
      chk("rr_grant", 32'(bus.req_ready), 32'(1 << (g % N)));
      tick();
      chk("rr_valid", 32'(bus.rsp_valid), 32'h1);
      chk("rr_id", 32'(bus.rsp_id), 32'(g % N));
      chk("rr_sum", bus.rsp_sum, 32'((g % N) * 16 + 1));
    end
    bus.req_valid = '0;
    tick();
    chk("drain_valid", 32'(bus.rsp_valid), 32'h0);

    // single-requester vectors, issued back to back
    for (int v = 0; v < 8; v++) begin
      set_op(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].sub);
      bus.req_valid = 4'(1 << vecs[v].id);
      #1;
      chk("vec_ready", 32'(bus.req_ready), 32'(1 << vecs[v].id));
      tick();
      bus.req_valid = '0;
      chk("vec_valid", 32'(bus.rsp_valid), 32'h1);
      chk("vec_id", 32'(bus.rsp_id), 32'(vecs[v].id));
      chk("vec_sum", bus.rsp_sum, vecs[v].sum);
      chk("vec_cout", 32'(bus.rsp_cout), 32'(vecs[v].cout));
`ifdef ADD_SUB_SCHED_OVF_EN
      chk("vec_ovf", 32'(bus.rsp_ovf), 32'(vecs[v].ovf));
`endif
    end
    tick();
    chk("vec_drain", 32'(bus.rsp_valid), 32'h0);

    // backpressure: result held, req1 waits for the slot
    bus.rsp_ready = 1'b0;
    set_op(0, 32'h12345678, 32'h0, 1'b0);
    bus.req_valid = 4'b0001;
    #1;
    chk("bp_load", 32'(bus.req_ready), 32'h1);
    tick();
    set_op(1, 32'h7, 32'h2, 1'b1);
    bus.req_valid = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_valid", 32'(bus.rsp_valid), 32'h1);
      chk("bp_sum", bus.rsp_sum, 32'h12345678);
      chk("bp_id", 32'(bus.rsp_id), 32'h0);
      chk("bp_ready", 32'(bus.req_ready), 32'h0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("bp_grant", 32'(bus.req_ready), 32'h2);
    tick();
    bus.req_valid = '0;
    chk("bp_rsp_id", 32'(bus.rsp_id), 32'h1);
    chk("bp_rsp_sum", bus.rsp_sum, 32'h5);
    chk("bp_rsp_cout", 32'(bus.rsp_cout), 32'h1);

    // reset while a result is held drops it and rewinds ptr
    bus.rsp_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("mid_rst_valid", 32'(bus.rsp_valid), 32'h0);
    chk("mid_rst_sum", bus.rsp_sum, 32'h0);
    rst_n         = 1'b1;
    bus.req_valid = '1;
    #1;
    chk("mid_rst_grant", 32'(bus.req_ready), 32'h1);
    bus.req_valid = '0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
